// File: rtl/prim_claim_gateway_pkg.sv
// prim_claim_gateway_pkg
//   Shared types for the claim gateway: the per-source FSM state encoding
//   and the per-source status bundle that the source slices report upward.
package prim_claim_gateway_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACTIVE  = 2'd2
  } gw_state_e;

  typedef struct packed {
    logic pending;
    logic active;
  } gw_src_status_t;

endpackage

// File: rtl/prim_claim_gateway_src.sv
// prim_claim_gateway_src
//   One request source: IDLE/PENDING/ACTIVE FSM, optional rising-edge
//   detect and rearm bit (built only with PRIM_CLAIM_GATEWAY_EDGE_EN).
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   src_i         raw request line
//   le_i          1 = edge-triggered, 0 = level (ignored without the macro)
//   claim_i       accepted claim addressed to this source
//   complete_i    complete addressed to this source
//   status_o      {pending, active}
module prim_claim_gateway_src
  import prim_claim_gateway_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           src_i,
  input  logic           le_i,
  input  logic           claim_i,
  input  logic           complete_i,
  output gw_src_status_t status_o
);

  gw_state_e state_q, state_d;
  logic      req;        // new request seen this cycle (mode dependent)
  logic      rearm_now;  // ACTIVE->PENDING instead of ACTIVE->IDLE on complete

`ifdef PRIM_CLAIM_GATEWAY_EDGE_EN
  logic src_q, rearm_q, rise;

  // src_q resets to 0 so a line already high at reset release is an edge
  assign rise = src_i & ~src_q;
  assign req  = le_i ? rise : src_i;
  // an edge landing in the completing cycle must not be lost either
  assign rearm_now = rearm_q | (le_i & rise);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q   <= 1'b0;
      rearm_q <= 1'b0;
    end else begin
      src_q <= src_i;
      if (state_q == ACTIVE && complete_i)         rearm_q <= 1'b0;
      else if (state_q == ACTIVE && le_i && rise)  rearm_q <= 1'b1;
    end
  end
`else
  logic unused_le;
  assign unused_le = le_i;
  assign req       = src_i;
  assign rearm_now = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A request arriving while PENDING/ACTIVE is absorbed (level) or turned
  // into rearm (edge); a claim always beats a coincident request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req)        state_d = PENDING;
      PENDING: if (claim_i)    state_d = ACTIVE;
      ACTIVE:  if (complete_i) state_d = rearm_now ? PENDING : IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    status_o.pending = (state_q == PENDING);
    status_o.active  = (state_q == ACTIVE);
  end

endmodule

// File: rtl/prim_claim_gateway.sv
// prim_claim_gateway
//   Request gateway + claim/complete responder in front of an external
//   max-selection tree. Edge mode is built with PRIM_CLAIM_GATEWAY_EDGE_EN.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   src_i, le_i         request lines and per-source edge/level mode
//   prio_i, threshold_i per-source priority, target threshold
//   sel_valid_o         eligible mask to the tree (pending && prio > threshold)
//   sel_value_o         priorities to the tree (= prio_i)
//   max_valid_i/idx_i   tree result
//   pending_o/active_o  per-source state
//   claim_req_i -> claim_ack_o/claim_valid_o/claim_id_o one cycle later
//   complete_req_i/complete_id_i -> complete_err_o one cycle later
module prim_claim_gateway
  import prim_claim_gateway_pkg::*;
#(
  parameter  int NumSrc   = 32,
  parameter  int Width    = 8,
  localparam int SrcWidth = $clog2(NumSrc)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumSrc-1:0]              src_i,
  input  logic [NumSrc-1:0]              le_i,
  input  logic [NumSrc-1:0][Width-1:0]   prio_i,
  input  logic [Width-1:0]               threshold_i,
  output logic [NumSrc-1:0]              sel_valid_o,
  output logic [NumSrc-1:0][Width-1:0]   sel_value_o,
  input  logic                           max_valid_i,
  input  logic [SrcWidth-1:0]            max_idx_i,
  output logic [NumSrc-1:0]              pending_o,
  output logic [NumSrc-1:0]              active_o,
  input  logic                           claim_req_i,
  output logic                           claim_ack_o,
  output logic                           claim_valid_o,
  output logic [SrcWidth-1:0]            claim_id_o,
  input  logic                           complete_req_i,
  input  logic [SrcWidth-1:0]            complete_id_i,
  output logic                           complete_err_o
);

  gw_src_status_t [NumSrc-1:0] status;
  logic [NumSrc-1:0]           claim_hit, complete_hit;
  logic                        claim_go, complete_ok;

  assign claim_go = claim_req_i & max_valid_i;

  for (genvar k = 0; k < NumSrc; k++) begin : g_src
    assign claim_hit[k]    = claim_go && (max_idx_i == SrcWidth'(k));
    assign complete_hit[k] = complete_req_i && (complete_id_i == SrcWidth'(k));

    prim_claim_gateway_src u_src (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .src_i      (src_i[k]),
      .le_i       (le_i[k]),
      .claim_i    (claim_hit[k]),
      .complete_i (complete_hit[k]),
      .status_o   (status[k])
    );

    assign pending_o[k]   = status[k].pending;
    assign active_o[k]    = status[k].active;
    // prio > threshold also excludes prio 0, since threshold is unsigned
    assign sel_valid_o[k] = status[k].pending && (prio_i[k] > threshold_i);
  end

  assign sel_value_o = prio_i;

  // An out-of-range id decodes to no bit, so it falls into the error case too
  assign complete_ok = |(complete_hit & active_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      claim_ack_o    <= 1'b0;
      claim_valid_o  <= 1'b0;
      claim_id_o     <= '0;
      complete_err_o <= 1'b0;
    end else begin
      claim_ack_o    <= claim_req_i;
      claim_valid_o  <= claim_go;
      claim_id_o     <= claim_go ? max_idx_i : '0;
      complete_err_o <= complete_req_i & ~complete_ok;
    end
  end

endmodule

// File: tb/tb_prim_claim_gateway.sv
module tb_prim_claim_gateway;
  localparam int NumSrc   = 24;
  localparam int Width    = 8;
  localparam int SrcWidth = $clog2(NumSrc);

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NumSrc-1:0]            src, le, sel_valid, pending, active;
  logic [NumSrc-1:0][Width-1:0] prio, sel_value;
  logic [Width-1:0]             thr;
  logic                         max_valid, claim_req, claim_ack, claim_valid;
  logic                         complete_req, complete_err;
  logic [SrcWidth-1:0]          max_idx, claim_id, complete_id;

  int n_vec = 0, n_err = 0;

  // reference model: sets of pending / in-service / rearmed sources
  bit [NumSrc-1:0] m_pend, m_act, m_rearm, m_prev;

  always #5 clk = ~clk;

  prim_claim_gateway #(.NumSrc(NumSrc), .Width(Width)) dut (
    .clk_i(clk), .rst_i(rst), .src_i(src), .le_i(le), .prio_i(prio),
    .threshold_i(thr), .sel_valid_o(sel_valid), .sel_value_o(sel_value),
    .max_valid_i(max_valid), .max_idx_i(max_idx), .pending_o(pending),
    .active_o(active), .claim_req_i(claim_req), .claim_ack_o(claim_ack),
    .claim_valid_o(claim_valid), .claim_id_o(claim_id),
    .complete_req_i(complete_req), .complete_id_i(complete_id),
    .complete_err_o(complete_err)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit edge_mode(int k);
`ifdef PRIM_CLAIM_GATEWAY_EDGE_EN
    return le[k];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [NumSrc-1:0] eligible();
    logic [NumSrc-1:0] e = '0;
    for (int k = 0; k < NumSrc; k++) e[k] = m_pend[k] && (prio[k] > thr);
    return e;
  endfunction

  // One clock: play the tree, check comb outputs, advance model, check regs.
  task automatic step();
    logic [NumSrc-1:0] e;
    bit [NumSrc-1:0]   n_pend, n_act, n_rearm;
    bit                claimed, cmp_ok, e_err, rise, req;
    logic [SrcWidth-1:0] e_id;
    int best, k;
    e = eligible();
    best = -1;
    for (int i = 0; i < NumSrc; i++)
      if (e[i] && (best < 0 || prio[i] > prio[best])) best = i;
    max_valid = (best >= 0);
    max_idx   = (best >= 0) ? SrcWidth'(best) : SrcWidth'($urandom);
    #1;
    chk("sel_valid", 64'(sel_valid), 64'(e));
    k = $urandom_range(NumSrc-1);
    chk("sel_value", 64'(sel_value[k]), 64'(prio[k]));

    claimed = claim_req && max_valid;
    e_id    = claimed ? max_idx : '0;
    cmp_ok  = complete_req && (int'(complete_id) < NumSrc) && m_act[complete_id];
    e_err   = complete_req && !cmp_ok;
    n_pend = m_pend; n_act = m_act; n_rearm = m_rearm;
    for (int i = 0; i < NumSrc; i++) begin
      rise = src[i] && !m_prev[i];
      req  = edge_mode(i) ? rise : src[i];
      if (m_pend[i]) begin
        if (claimed && int'(max_idx) == i) begin n_pend[i] = 0; n_act[i] = 1; end
      end else if (m_act[i]) begin
        if (cmp_ok && int'(complete_id) == i) begin
          n_act[i] = 0; n_pend[i] = m_rearm[i] || (edge_mode(i) && rise); n_rearm[i] = 0;
        end else if (edge_mode(i) && rise) n_rearm[i] = 1;
      end else if (req) n_pend[i] = 1;
    end
    if (rst) begin
      n_pend = '0; n_act = '0; n_rearm = '0;
      claimed = 0; e_id = '0; e_err = 0;
    end
    @(posedge clk);
    m_pend = n_pend; m_act = n_act; m_rearm = n_rearm;
    m_prev = rst ? '0 : src;
    #1;
    chk("pending", 64'(pending), 64'(m_pend));
    chk("active", 64'(active), 64'(m_act));
    chk("claim_ack", 64'(claim_ack), 64'(claim_req && !rst));
    chk("claim_valid", 64'(claim_valid), 64'(claimed));
    chk("claim_id", 64'(claim_id), 64'(e_id));
    chk("complete_err", 64'(complete_err), 64'(e_err));
    claim_req = 0; complete_req = 0;
  endtask

  task automatic do_reset();
    rst = 1; src = '0; step(); rst = 0;
  endtask

  initial begin
    rst = 1; src = '0; le = '0; prio = '0; thr = '0;
    claim_req = 0; complete_req = 0; complete_id = '0;
    max_valid = 0; max_idx = '0;
    step(); step();
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_err", 64'(complete_err), 64'd0);
    rst = 0;

    // level request, claim
    prio[3] = 8'd5; src[3] = 1; step();
    chk("lvl_pend3", 64'(pending[3]), 64'd1);
    claim_req = 1; step();
    chk("lvl_id", 64'(claim_id), 64'd3);
    chk("lvl_valid", 64'(claim_valid), 64'd1);
    chk("lvl_act3", 64'(active[3]), 64'd1);

    // tie on priority, back-to-back claims
    do_reset(); prio = '0; prio[2] = 8'd4; prio[7] = 8'd4;
    src[2] = 1; src[7] = 1; step(); src = '0;
    claim_req = 1; step(); chk("b2b_id0", 64'(claim_id), 64'd2);
    claim_req = 1; step(); chk("b2b_id1", 64'(claim_id), 64'd7);
    claim_req = 1; step(); chk("b2b_none", 64'({claim_valid, claim_id}), 64'd0);

    // completes to idle and out-of-range sources
    complete_req = 1; complete_id = 5'd9; step();
    chk("err_idle", 64'(complete_err), 64'd1);
    complete_req = 1; complete_id = 5'd30; step();
    chk("err_range", 64'(complete_err), 64'd1);
    chk("err_nochg", 64'(active), 64'(24'h84));

    // threshold compare, prio 0 never eligible
    do_reset(); prio = '0; thr = 8'd6; prio[1] = 8'd6; prio[4] = 8'd7;
    src[1] = 1; src[4] = 1; src[9] = 1; step(); #1;
    chk("thr_mask", 64'(sel_valid), 64'(24'h10));
    thr = 8'd0; #1;
    chk("prio0_mask", 64'(sel_valid[9]), 64'd0);

    // reset mid-service; level source re-pends after release
    do_reset(); prio[0] = 8'd9; prio[1] = 8'd8; src[0] = 1; src[1] = 1; step();
    claim_req = 1; step(); claim_req = 1; step();
    chk("pre_rst_act", 64'(active[1:0]), 64'd3);
    rst = 1; step();
    chk("rst_act", 64'(active), 64'd0);
    rst = 0; src[1] = 0; step();
    chk("re_pend0", 64'(pending[0]), 64'd1);

`ifdef PRIM_CLAIM_GATEWAY_EDGE_EN
    // edge source pulsed while in service rearms once
    do_reset(); prio = '0; le = '0; le[5] = 1; prio[5] = 8'd3;
    src[5] = 1; step(); src[5] = 0; step();
    claim_req = 1; step();
    for (int p = 0; p < 3; p++) begin src[5] = 1; step(); src[5] = 0; step(); end
    complete_req = 1; complete_id = 5'd5; step();
    chk("rearm_pend", 64'(pending[5]), 64'd1);
    claim_req = 1; step();
    complete_req = 1; complete_id = 5'd5; step();
    chk("rearm_idle", 64'({pending[5], active[5]}), 64'd0);
`endif

    // randomized traffic
    do_reset();
    le = NumSrc'($urandom);
    for (int i = 0; i < NumSrc; i++) prio[i] = Width'($urandom_range(10));
    for (int c = 0; c < 1500; c++) begin
      src = src ^ NumSrc'($urandom & $urandom & $urandom);
      if ($urandom_range(9) == 0) thr = Width'($urandom_range(6));
      if ($urandom_range(19) == 0) prio[$urandom_range(NumSrc-1)] = Width'($urandom_range(10));
      if ($urandom_range(49) == 0) le = NumSrc'($urandom);
      claim_req    = ($urandom_range(2) == 0);
      complete_req = ($urandom_range(2) == 0);
      complete_id  = SrcWidth'($urandom);
      if ($urandom_range(4) != 0)
        for (int t = 0; t < 8; t++) begin
          int j = $urandom_range(NumSrc-1);
          if (m_act[j]) begin complete_id = SrcWidth'(j); break; end
        end
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
